// File: rtl/rom_seq_player_pkg.sv
// Shared definitions for the ROM sequence player: default widths and state codes.
package rom_seq_player_pkg;

  localparam int unsigned SEQ_AW     = 6;
  localparam int unsigned SEQ_DW     = 8;
  localparam int unsigned SEQ_PACE_W = 16;

  // State codes are shared with the table and the downstream consumer.
  localparam int unsigned ST_W       = 3;
  localparam logic [2:0]  ST_IDLE    = 3'd0;
  localparam logic [2:0]  ST_FETCH   = 3'd1;
  localparam logic [2:0]  ST_PRESENT = 3'd2;
  localparam logic [2:0]  ST_PACE    = 3'd3;
  localparam logic [2:0]  ST_DONE    = 3'd4;

endpackage

// File: rtl/rom_seq_pace_timer.sv
// Loadable down-counter timing the idle gap between delivered bytes.
module rom_seq_pace_timer
  import rom_seq_player_pkg::*;
#(
  parameter int unsigned PACE_W = SEQ_PACE_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [PACE_W-1:0] load_val,
  output logic              expire_c
);

  logic [PACE_W-1:0] cnt_q, cnt_d;

  // Load wins; otherwise count down and rest at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - PACE_W'(1);
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Last idle cycle of the gap.
  assign expire_c = (cnt_q == PACE_W'(1));

endmodule

// File: rtl/rom_seq_player.sv
// Plays an address window of the constant table onto a valid/ready byte stream.
module rom_seq_player
  import rom_seq_player_pkg::*;
#(
  parameter int unsigned AW     = SEQ_AW,
  parameter int unsigned DW     = SEQ_DW,
  parameter int unsigned PACE_W = SEQ_PACE_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [AW-1:0]     first_addr,
  input  logic [AW-1:0]     last_addr,
  input  logic              loop,
  input  logic [PACE_W-1:0] pace,
  output logic [AW-1:0]     rom_a,
  input  logic [DW-1:0]     rom_q,
  output logic [DW-1:0]     out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  logic [ST_W-1:0]   state_q, state_d;
  logic [AW-1:0]     rom_a_q, rom_a_d;
  logic [AW-1:0]     first_q, first_d;
  logic [AW-1:0]     last_q, last_d;
  logic              loop_q, loop_d;
  logic [PACE_W-1:0] pace_q, pace_d;
  logic [DW-1:0]     out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              xfer_c;
  logic              pace_load_c;
  logic              pace_expire_c;

  assign xfer_c = out_valid_q & out_ready;

  rom_seq_pace_timer #(
    .PACE_W (PACE_W)
  ) u_pace_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (pace_load_c),
    .load_val (pace_q),
    .expire_c (pace_expire_c)
  );

  // Next-state, address stepping and output decode; abort overrides at the end.
  always_comb begin
    state_d     = state_q;
    rom_a_d     = rom_a_q;
    first_d     = first_q;
    last_d      = last_q;
    loop_d      = loop_q;
    pace_d      = pace_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    pace_load_c = 1'b0;

    case (state_q)
      ST_IDLE: begin
        busy_d      = 1'b0;
        out_valid_d = 1'b0;
        if (start) begin
          first_d = first_addr;
          last_d  = last_addr;
          loop_d  = loop;
          pace_d  = pace;
          rom_a_d = first_addr;
          busy_d  = 1'b1;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        out_data_d  = rom_q;
        out_valid_d = 1'b1;
        state_d     = ST_PRESENT;
      end
      ST_PRESENT: begin
        if (xfer_c) begin
          out_valid_d = 1'b0;
          if ((rom_a_q == last_q) && !loop_q) begin
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            rom_a_d = (rom_a_q == last_q) ? first_q : rom_a_q + AW'(1);
            if (pace_q == '0) begin
              state_d = ST_FETCH;
            end else begin
              pace_load_c = 1'b1;
              state_d     = ST_PACE;
            end
          end
        end
      end
      ST_PACE: begin
        if (pace_expire_c) begin
          state_d = ST_FETCH;
        end
      end
      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        busy_d      = 1'b0;
        out_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase

    // A coincident transfer still completes downstream; only local progress is dropped.
    if (abort && (state_q != ST_IDLE)) begin
      state_d     = ST_IDLE;
      rom_a_d     = rom_a_q;
      out_data_d  = out_data_q;
      out_valid_d = 1'b0;
      busy_d      = 1'b0;
      done_d      = 1'b0;
      pace_load_c = 1'b0;
    end
  end

  // State, config and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rom_a_q     <= '0;
      first_q     <= '0;
      last_q      <= '0;
      loop_q      <= 1'b0;
      pace_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rom_a_q     <= rom_a_d;
      first_q     <= first_d;
      last_q      <= last_d;
      loop_q      <= loop_d;
      pace_q      <= pace_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign rom_a     = rom_a_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
